// File: rtl/l2_i_resp_pkg.sv
// Shared definitions for the L2 instruction response path: address geometry,
// line width defaults and the controller state encoding.
package l2_i_resp_pkg;

  localparam int ADDR_W     = 26;
  localparam int LINE_W_DEF = 512;
  localparam int TNUM_2_DEF = 18;
  localparam int INUM_2_DEF = ADDR_W - TNUM_2_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_RESP,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/l2_i_resp_array.sv
// Direct-mapped line store: valid bits (resettable, flushable), plus tag and
// data arrays (not reset). One asynchronous read port, one write port.
module l2_i_resp_array #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [INUM_2-1:0] rd_index,
  output logic              rd_valid,
  output logic [TNUM_2-1:0] rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [INUM_2-1:0] wr_index,
  input  logic [TNUM_2-1:0] wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  localparam int SETS = 1 << INUM_2;

  logic [SETS-1:0]   valid_q, valid_d;
  logic [TNUM_2-1:0] tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // A refill landing on the same edge as a flush keeps its own set valid.
  always_comb begin
    valid_d = valid_q;
    if (flush) valid_d = '0;
    if (wr_en) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/l2_i_resp.sv
// L2 instruction-side responder: direct-mapped lookup, memory refill on miss,
// single-pulse response. Optional hit/miss counters under L2_I_PERF_CNT_EN.
module l2_i_resp
  import l2_i_resp_pkg::*;
#(
  parameter int TNUM_2 = TNUM_2_DEF,
  parameter int INUM_2 = ADDR_W - TNUM_2,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_L1_L2,
  input  logic [TNUM_2-1:0] tag_L1_L2,
  input  logic [INUM_2-1:0] index_L1_L2,
  input  logic              flush,
  output logic              ready_L2_L1,
  output logic [LINE_W-1:0] read_data_L2_L1,
  output logic              read_L2_M,
  output logic [ADDR_W-1:0] addr_L2_M,
  input  logic              ready_M_L2,
  input  logic [LINE_W-1:0] read_data_M_L2
`ifdef L2_I_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  state_e            state_q, state_d;
  logic [TNUM_2-1:0] tag_q, tag_d;
  logic [INUM_2-1:0] index_q, index_d;
  logic [LINE_W-1:0] data_q, data_d;

  logic              rd_valid;
  logic [TNUM_2-1:0] rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              wr_en;
  logic              hit;

  l2_i_resp_array #(
    .TNUM_2 (TNUM_2),
    .INUM_2 (INUM_2),
    .LINE_W (LINE_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .rd_index (index_q),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (index_q),
    .wr_tag   (tag_q),
    .wr_data  (read_data_M_L2)
  );

  assign hit = rd_valid && (rd_tag == tag_q);

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    index_d = index_q;
    data_d  = data_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_L1_L2) begin
          tag_d   = tag_L1_L2;
          index_d = index_L1_L2;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          data_d  = rd_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        if (ready_M_L2) begin
          wr_en   = 1'b1;
          data_d  = read_data_M_L2;
          state_d = ST_RESP;
        end
      end
      ST_RESP:    state_d = ST_RELEASE;
      // Wait for L1 to drop its request so one request is served only once.
      ST_RELEASE: if (!read_L1_L2) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign ready_L2_L1     = (state_q == ST_RESP);
  assign read_L2_M       = (state_q == ST_MISS);
  assign addr_L2_M       = ADDR_W'({tag_q, index_q});
  assign read_data_L2_L1 = data_q;

`ifdef L2_I_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_LOOKUP) begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l2_i_resp.sv
// Self-checking bench for l2_i_resp: directed scenarios plus randomized
// requests predicted by a set-indexed reference model of the cache contents.
module tb_l2_i_resp;
  import l2_i_resp_pkg::*;

  localparam int TN = 18;
  localparam int IN = 8;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_L1_L2 = 1'b0;
  logic [TN-1:0] tag_L1_L2 = '0;
  logic [IN-1:0] index_L1_L2 = '0;
  logic          flush = 1'b0;
  logic          ready_L2_L1;
  logic [LW-1:0] read_data_L2_L1;
  logic          read_L2_M;
  logic [25:0]   addr_L2_M;
  logic          ready_M_L2 = 1'b0;
  logic [LW-1:0] read_data_M_L2 = '0;
`ifdef L2_I_PERF_CNT_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  l2_i_resp dut (
    .clk             (clk),
    .rst             (rst),
    .read_L1_L2      (read_L1_L2),
    .tag_L1_L2       (tag_L1_L2),
    .index_L1_L2     (index_L1_L2),
    .flush           (flush),
    .ready_L2_L1     (ready_L2_L1),
    .read_data_L2_L1 (read_data_L2_L1),
    .read_L2_M       (read_L2_M),
    .addr_L2_M       (addr_L2_M),
    .ready_M_L2      (ready_M_L2),
    .read_data_M_L2  (read_data_M_L2)
`ifdef L2_I_PERF_CNT_EN
    ,
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each set holds, plus expected counter values.
  bit            ref_valid [256];
  logic [TN-1:0] ref_tag   [256];
  logic [LW-1:0] ref_data  [256];
  logic [LW-1:0] last_line = '0;
  int            ref_hits = 0;
  int            ref_misses = 0;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
  endtask

  // One L1 request. flush_mode: 0 none, 1 flush on the refill edge,
  // 2 flush on the first MISS cycle (before refill).
  task automatic run_req(input logic [TN-1:0] t, input logic [IN-1:0] ix,
                         input logic [LW-1:0] mdata, input int mdelay,
                         input int hold, input int flush_mode, input string nm);
    bit            exp_hit, saw_mreq, addr_ok, hold_ok;
    logic [LW-1:0] exp_line;
    int            k, mreq_cnt, m_k, first_k, pulses;
    exp_hit  = ref_valid[ix] && (ref_tag[ix] == t);
    exp_line = exp_hit ? ref_data[ix] : mdata;
    @(negedge clk);
    read_L1_L2 = 1'b1; tag_L1_L2 = t; index_L1_L2 = ix;
    @(posedge clk);
    #1;
    tag_L1_L2 = TN'($urandom); index_L1_L2 = IN'($urandom);
    k = 0; mreq_cnt = 0; m_k = -100; first_k = -1; pulses = 0;
    saw_mreq = 1'b0; addr_ok = 1'b1;
    while (first_k < 0 && k < 60) begin
      @(negedge clk);
      k++;
      ready_M_L2 = 1'b0;
      flush = 1'b0;
      if (read_L2_M) begin
        saw_mreq = 1'b1;
        if (addr_L2_M !== {t, ix}) addr_ok = 1'b0;
        if (mreq_cnt == 0 && flush_mode == 2) flush = 1'b1;
        if (mreq_cnt == mdelay) begin
          ready_M_L2 = 1'b1; read_data_M_L2 = mdata; m_k = k;
          if (flush_mode == 1) flush = 1'b1;
        end
        mreq_cnt++;
      end
      if (ready_L2_L1) begin first_k = k; pulses = 1; end
    end
    n_checks++;
    if (first_k < 0) begin
      n_errors++;
      $display("FAIL %s timeout: no ready_L2_L1 within %0d cycles", nm, k);
    end else if (exp_hit) begin
      if (first_k !== 2 || saw_mreq) begin
        n_errors++;
        $display("FAIL %s hit: latency=%0d mem_req=%0d required latency=2 mem_req=0", nm, first_k, saw_mreq);
      end
    end else begin
      if (!saw_mreq || first_k !== m_k + 1) begin
        n_errors++;
        $display("FAIL %s miss: mem_req=%0d ready_at=%0d required mem_req=1 ready_at=%0d", nm, saw_mreq, first_k, m_k + 1);
      end
    end
    n_checks++;
    if (!addr_ok) begin
      n_errors++;
      $display("FAIL %s addr: got %h required %h", nm, addr_L2_M, {t, ix});
    end
    n_checks++;
    if (read_data_L2_L1 !== exp_line) begin
      n_errors++;
      $display("FAIL %s data: got %h required %h", nm, read_data_L2_L1[63:0], exp_line[63:0]);
    end
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      ready_M_L2 = 1'b0; flush = 1'b0;
      if (ready_L2_L1) pulses++;
      if (read_data_L2_L1 !== exp_line) hold_ok = 1'b0;
    end
    read_L1_L2 = 1'b0;
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      ready_M_L2 = 1'b0; flush = 1'b0;
      if (ready_L2_L1) pulses++;
      if (read_data_L2_L1 !== exp_line) hold_ok = 1'b0;
    end
    n_checks++;
    if (pulses !== 1 || !hold_ok) begin
      n_errors++;
      $display("FAIL %s pulses: got %0d data_held=%0d required 1 data_held=1", nm, pulses, hold_ok);
    end
    if (exp_hit) begin
      ref_hits++;
    end else begin
      ref_misses++;
      if (flush_mode != 0) model_clear();
      ref_valid[ix] = 1'b1; ref_tag[ix] = t; ref_data[ix] = mdata;
    end
    last_line = exp_line;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready_L2_L1 !== 1'b0 || read_L2_M !== 1'b0 || addr_L2_M !== 26'd0 || read_data_L2_L1 !== '0) begin
      n_errors++;
      $display("FAIL reset: ready=%b mreq=%b addr=%h data0=%h required all zero", ready_L2_L1, read_L2_M, addr_L2_M, read_data_L2_L1[31:0]);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    run_req(18'h00ABC, 8'h05, {64{8'hA5}}, 3, 0, 0, "cold_miss");
  endtask

  task automatic test_hit();
    run_req(18'h00ABC, 8'h05, rand_line(), 3, 0, 0, "hit");
  endtask

  task automatic test_conflict();
    run_req(18'h00ABD, 8'h05, rand_line(), 2, 0, 0, "conflict_a");
    run_req(18'h00ABC, 8'h05, {64{8'h3C}}, 1, 0, 0, "conflict_b");
  endtask

  task automatic test_held();
    run_req(18'h00ABC, 8'h05, rand_line(), 0, 10, 0, "held_hit");
    run_req(18'h01111, 8'h06, rand_line(), 2, 10, 0, "held_miss");
  endtask

  task automatic test_ignore_mreq();
    @(negedge clk);
    ready_M_L2 = 1'b1; read_data_M_L2 = rand_line();
    @(negedge clk);
    ready_M_L2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (read_data_L2_L1 !== last_line || ready_L2_L1 !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_mreq: data=%h ready=%b required data=%h ready=0", read_data_L2_L1[63:0], ready_L2_L1, last_line[63:0]);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 64; i++) run_req(18'h01234, IN'(i), rand_line(), i % 3, 0, 0, "flush_fill");
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    model_clear();
    for (int i = 0; i < 64; i++) run_req(18'h01234, IN'(i), rand_line(), 1, 0, 0, "flush_reread");
  endtask

  task automatic test_flush_in_miss();
    run_req(18'h00777, 8'h40, rand_line(), 2, 0, 1, "flush_refill_edge");
    run_req(18'h00777, 8'h40, rand_line(), 1, 0, 0, "flush_refill_hit");
    run_req(18'h01234, 8'h00, rand_line(), 1, 0, 0, "flush_other_miss");
    run_req(18'h00888, 8'h41, rand_line(), 3, 0, 2, "flush_early_miss");
    run_req(18'h00888, 8'h41, rand_line(), 0, 0, 0, "flush_early_hit");
    run_req(18'h01234, 8'h00, rand_line(), 0, 0, 0, "flush_early_other");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [TN-1:0] t;
      logic [IN-1:0] ix;
      t  = ($urandom_range(0, 1) == 0) ? 18'h00100 : 18'h00200;
      ix = IN'(8'hC0 + $urandom_range(0, 3));
      run_req(t, ix, rand_line(), $urandom_range(0, 4), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0) ? 1 : 0, "random");
    end
  endtask

  task automatic test_reset_mid_miss();
    int  w;
    bit  bad;
    @(negedge clk);
    read_L1_L2 = 1'b1; tag_L1_L2 = 18'h2AAAA; index_L1_L2 = 8'h80;
    w = 0;
    while (!read_L2_M && w < 10) begin @(negedge clk); w++; end
    n_checks++;
    if (!read_L2_M) begin
      n_errors++;
      $display("FAIL rst_mid_miss setup: read_L2_M=%b required 1", read_L2_M);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (read_L2_M !== 1'b0 || ready_L2_L1 !== 1'b0 || addr_L2_M !== 26'd0 || read_data_L2_L1 !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_miss immediate: mreq=%b ready=%b addr=%h required 0 0 0", read_L2_M, ready_L2_L1, addr_L2_M);
    end
    read_L1_L2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    ref_hits = 0; ref_misses = 0; last_line = '0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready_L2_L1 || read_L2_M) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL rst_mid_miss after: spurious ready or memory request, required none");
    end
`ifdef L2_I_PERF_CNT_EN
    n_checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_counters: hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
    end
`endif
    run_req(18'h00ABC, 8'h05, rand_line(), 1, 0, 0, "post_reset_miss");
  endtask

  task automatic test_counters();
`ifdef L2_I_PERF_CNT_EN
    n_checks++;
    if (hit_cnt !== 32'(ref_hits) || miss_cnt !== 32'(ref_misses)) begin
      n_errors++;
      $display("FAIL counters: hit=%0d miss=%0d required %0d %0d", hit_cnt, miss_cnt, ref_hits, ref_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_held();
    test_ignore_mreq();
    test_flush();
    test_flush_in_miss();
    test_random();
    test_counters();
    test_reset_mid_miss();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
